// File: rtl/hash_unwind_if.sv
// hash_unwind_if: start/done request bus carrying the hash to unwind and the recovered state
interface hash_unwind_if #(parameter int NUM_ROUNDS = 8);
  logic                    start;
  logic [31:0]             final_state;
  logic [8*NUM_ROUNDS-1:0] msg;
  logic [31:0]             expected_init;
  logic                    busy;
  logic                    done;
  logic [31:0]             init_state;
  logic                    match;
  modport master (output start, final_state, msg, expected_init,
                  input  busy, done, init_state, match);
  modport slave  (input  start, final_state, msg, expected_init,
                  output busy, done, init_state, match);
endinterface

// File: rtl/hash_unwind.sv
// hash_unwind: undoes the byte-wise hash one round per clock, last round first, and returns the initial state
module hash_unwind #(parameter int NUM_ROUNDS = 8) (
  input logic          clk,
  input logic          rst_n,
  hash_unwind_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_work, r_exp, r_init;
  logic [63:0] r_msg;
  logic [2:0]  r_cnt;
  logic        r_done, r_match;
  logic [7:0]  w_c, w_b, w_rot, w_d, w_mix, w_byte, w_rr, w_a;
  always_comb begin
    w_c    = r_work[31:24];
    w_b    = r_work[23:16];
    w_rot  = r_work[15:8];
    w_d    = r_work[7:0];
    w_mix  = (r_cnt <= 3'd2) ? ((w_c & w_b) | (~w_b & w_d)) :
             (r_cnt <= 3'd4) ? ((w_c & w_b) | (w_b & w_d) | (w_c & w_d)) :
                               (w_b ^ w_c ^ w_d);
    w_byte = r_msg[{r_cnt, 3'b000} +: 8];
    w_rr   = (w_rot >> r_cnt) | (w_rot << (4'd8 - {1'b0, r_cnt}));
    w_a    = w_rr - w_mix - w_byte;
  end
  always_comb begin
    w_next = (r_state == IDLE) ? (bus.start ? RUN : IDLE) :
             (r_state == RUN)  ? ((r_cnt == 3'd0) ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // the counter exit test precedes the decrement, so it never wraps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_work  <= '0;
      r_msg   <= '0;
      r_exp   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_init  <= '0;
      r_match <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      if (r_state == IDLE && bus.start) begin
        r_work <= bus.final_state;
        r_msg  <= 64'(bus.msg);
        r_exp  <= bus.expected_init;
        r_cnt  <= 3'(NUM_ROUNDS - 1);
      end else if (r_state == RUN) begin
        r_work <= {w_d, w_c, w_b, w_a};
        if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
      end else if (r_state == DONE) begin
        r_init  <= r_work;
        r_match <= (r_work == r_exp);
      end
    end
  assign bus.busy       = (r_state == RUN);
  assign bus.done       = r_done;
  assign bus.init_state = r_init;
  assign bus.match      = r_match;
endmodule

// File: tb/tb_hash_unwind.sv
// tb_hash_unwind: random and directed checks of hash_unwind against a forward-hash reference model
module tb_hash_unwind;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  hash_unwind_if #(.NUM_ROUNDS(1)) b1();
  hash_unwind_if #(.NUM_ROUNDS(8)) b8();
  hash_unwind #(.NUM_ROUNDS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  hash_unwind #(.NUM_ROUNDS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  int n_checks = 0;
  int n_err = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] fwd(input logic [31:0] init, input logic [63:0] m, input int n);
    logic [7:0] a, b, c, d, mx, t, nt;
    {d, c, b, a} = init;
    for (int r = 0; r < n; r++) begin
      mx = (r < 3) ? ((c & b) | (~b & d)) : (r < 5) ? ((c & b) | (b & d) | (c & d)) : (b ^ c ^ d);
      t  = mx + a + m[8*r +: 8];
      nt = (t << (r % 8)) | (t >> (8 - r % 8));
      {d, c, b, a} = {c, b, nt, d};
    end
    return {d, c, b, a};
  endfunction
  task automatic run1(input logic [31:0] fs, input logic [7:0] m, input logic [31:0] ex,
                      input logic [31:0] ei, input logic em);
    int lat = -1;
    @(negedge clk);
    b1.start = 1'b1; b1.final_state = fs; b1.msg = m; b1.expected_init = ex;
    @(posedge clk); #1;
    b1.start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (b1.done) begin lat = k; break; end
    end
    check("n1_latency", 64'(lat), 64'd2);
    check("n1_init", 64'(b1.init_state), 64'(ei));
    check("n1_match", 64'(b1.match), 64'(em));
  endtask
  task automatic run8(input logic [31:0] fs, input logic [63:0] m, input logic [31:0] ex,
                      input logic [31:0] ei, input bit spam, input bit garbage);
    int lat = -1;
    bit busy_ok;
    @(negedge clk);
    b8.start = 1'b1; b8.final_state = fs; b8.msg = m; b8.expected_init = ex;
    @(posedge clk); #1;
    if (!spam) b8.start = 1'b0;
    if (garbage) begin
      b8.final_state = $urandom; b8.msg = {$urandom, $urandom}; b8.expected_init = $urandom;
    end
    busy_ok = b8.busy;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (b8.done) begin lat = k; break; end
      if ((k < 8 && !b8.busy) || (k >= 8 && b8.busy)) busy_ok = 1'b0;
    end
    b8.start = 1'b0;
    check("n8_latency", 64'(lat), 64'd9);
    check("n8_busy", 64'(busy_ok), 64'd1);
    check("n8_init", 64'(b8.init_state), 64'(ei));
    check("n8_match", 64'(b8.match), 64'(ex == ei));
    @(posedge clk); #1;
    check("n8_done_pulse", 64'(b8.done), 64'd0);
    if (spam) begin
      int extra = 0;
      repeat (12) begin
        @(posedge clk); #1;
        if (b8.busy || b8.done) extra++;
      end
      check("spam_extra", 64'(extra), 64'd0);
    end
  endtask
  initial begin
    logic [31:0] init, ex;
    logic [63:0] m;
    int extra;
    b1.start = 1'b0; b1.final_state = '0; b1.msg = '0; b1.expected_init = '0;
    b8.start = 1'b0; b8.final_state = '0; b8.msg = '0; b8.expected_init = '0;
    #3;
    check("rst_busy", 64'(b8.busy), 64'd0);
    check("rst_done", 64'(b8.done), 64'd0);
    check("rst_init", 64'(b8.init_state), 64'd0);
    check("rst_match", 64'(b8.match), 64'd0);
    #19 rst_n = 1'b1;
    run1(32'h0000_0500, 8'h05, 32'h0, 32'h0, 1'b1);
    run1(32'h1122_3344, 8'h00, 32'h4411_22EF, 32'h4411_22EF, 1'b1);
    run1(32'h1122_3344, 8'h00, 32'h0, 32'h4411_22EF, 1'b0);
    for (int i = 0; i < 200; i++) begin
      init = $urandom;
      m    = {$urandom, $urandom};
      ex   = $urandom_range(0, 1) ? init : $urandom;
      run8(fwd(init, m, 8), m, ex, init, i == 5 || i == 77, i % 7 == 3);
    end
    init = $urandom;
    m    = {$urandom, $urandom};
    @(negedge clk);
    b8.start = 1'b1; b8.final_state = fwd(init, m, 8); b8.msg = m; b8.expected_init = init;
    @(posedge clk); #1;
    b8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(b8.busy), 64'd0);
    check("abort_done", 64'(b8.done), 64'd0);
    check("abort_init", 64'(b8.init_state), 64'd0);
    check("abort_match", 64'(b8.match), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (b8.busy || b8.done) extra++;
    end
    check("abort_no_done", 64'(extra), 64'd0);
    init = $urandom;
    m    = {$urandom, $urandom};
    run8(fwd(init, m, 8), m, init, init, 1'b0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/hash_unwind.md
# hash_unwind

Multi-cycle inverse engine for the lab1 byte-wise hash. Given a final 32-bit hash state and the message bytes that produced it, it undoes the rounds one per clock, from the last round back to round 0, and returns the initial state. It also compares the recovered state against an expected initial value. It sits beside the forward hash chain, either as a self-check on the hash datapath or as a recovery unit for the starting value. It is built on a start/done handshake.

## Interface
- NUM_ROUNDS, 8, number of forward rounds to undo (1..8); round r used message byte r
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- final_state  input  32  hash output to unwind, {d,c,b,a} byte order, a = [7:0]
- msg  input  8*NUM_ROUNDS  message; byte r = msg[8r+7:8r]
- expected_init  input  32  initial state to compare against
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse, result valid
- init_state  output  32  recovered initial state; held until next accepted start
- match  output  1  init_state == expected_init; valid with done, held with init_state

## Operation
- Forward round r, for reference: in {d,c,b,a} -> out {c, b, rotl8(mix_r(b,c,d)+a+byte_r, r mod 8), d}. The 8-bit add is mod 256.
- mix_r is selected by the absolute round index r:
  - r in 0..2: (c&b)|(~b&d)
  - r in 3..4: majority (c&b)|(b&d)|(c&d)
  - r >= 5: b^c^d
- Inverse round r, from state s = {S3,S2,S1,S0}:
  - c = S3, b = S2, rot = S1, d = S0
  - a = rotr8(rot, r mod 8) - mix_r(b,c,d) - byte_r, mod 256
  - previous state = {d,c,b,a}
- Inverse datapath is combinational from the working register and the round counter. Exactly one inverse round per RUN cycle.
- FSM states:
  - IDLE: start=1 latches final_state into the working register, latches msg and expected_init, sets round counter to NUM_ROUNDS-1, and moves to RUN. start=0 stays in IDLE.
  - RUN: each edge writes the inverse-round result to the working register. If the counter is 0, move to DONE; otherwise decrement the counter.
  - DONE: latch init_state and match, assert done, return to IDLE unconditionally.
- Input sampling:
  - start in RUN or DONE is ignored; no queueing.
  - final_state, msg and expected_init may change freely after the accepting edge.
- Round counter is 3 bits and never wraps: the RUN exit at counter 0 is checked before the decrement.

## Timing
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE.
  - busy=0, done=0, init_state=32'h0, match=0.
  - Working register and counter are cleared.
- Reset asserted mid-RUN aborts the operation. No done pulse is produced, and init_state/match keep their reset values.
- Latency: start accepted at edge E0.
  - busy is high from after E0 through edge E0+NUM_ROUNDS.
  - done is high for exactly one cycle after edge E0+NUM_ROUNDS+1.
  - init_state and match update at that same edge.
- Throughput: a new start is accepted in the cycle done is high (FSM is back in IDLE at that edge's sampling? no). Precisely: start is sampled at the edge that leaves DONE is NOT accepted; the earliest acceptance is the edge after done. Minimum start-to-start spacing is NUM_ROUNDS+2 cycles.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- NUM_ROUNDS=1, final_state=32'h0000_0500, msg=8'h05, expected_init=0 -> done 2 cycles after the accepting edge; init_state=32'h0000_0000, match=1.
- NUM_ROUNDS=1, final_state=32'h1122_3344, msg=8'h00, expected_init=32'h4411_22EF -> init_state=32'h4411_22EF, match=1. Repeat with expected_init=0 -> match=0.
- NUM_ROUNDS=8, 200 random (init, msg) pairs run through a bench forward-hash model (rotl by r, mix as above), then unwound -> init_state equals the model's init every time; done exactly 9 cycles after each accepting edge.
- Start pulsed every cycle during RUN and during DONE -> only the first start is accepted; exactly one done per accepted start, and busy never glitches low mid-run.
- rst_n dropped asynchronously at round 4 of an 8-round run -> busy/done/init_state/match go to 0 immediately. A fresh start after release completes normally with the correct result.
- Inputs changed to garbage on the cycle after acceptance -> result still matches the latched values.
